// File: rtl/mult_scheduler.sv
// Shares one sequential 16x16 Booth multiplier among N_REQ requesters, one job at a time.
// Define MULT_SCHED_RR_EN for round-robin grant; otherwise the lowest valid index wins.
module mult_scheduler #(
   parameter int N_REQ      = 4,
   parameter int MUL_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [16*N_REQ-1:0]  req_mc,
   input  logic [16*N_REQ-1:0]  req_mp,
   output logic                 mul_start,
   output logic [15:0]          mul_mc,
   output logic [15:0]          mul_mp,
   input  logic [31:0]          mul_prod,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2:0]           rsp_id,
   output logic [31:0]          rsp_prod,
   output logic                 busy
);

   localparam int CW = $clog2(MUL_CYCLES + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_CAPT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    id_q;
   logic          cool;
   logic          found;
   logic          grant;
   logic [2:0]    gnt;
   logic [15:0]   sel_mc;
   logic [15:0]   sel_mp;
`ifdef MULT_SCHED_RR_EN
   logic [2:0]    ptr;
`endif

   // Round-robin: indices above the last grant first, then wrap to the rest.
   always_comb begin
      found  = 1'b0;
      gnt    = '0;
      sel_mc = '0;
      sel_mp = '0;
`ifdef MULT_SCHED_RR_EN
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[i] && 3'(i) > ptr) begin
            found = 1'b1;
            gnt   = 3'(i);
         end
      end
`endif
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            gnt   = 3'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt == 3'(i)) begin
            sel_mc = req_mc[16*i +: 16];
            sel_mp = req_mp[16*i +: 16];
         end
      end
   end

   // cool keeps the first IDLE cycle after a response free of grants.
   assign grant = (state == S_IDLE) && !cool && found;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (gnt == 3'(i));
      end
   end

   assign mul_start = (state == S_LOAD);
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         id_q     <= '0;
         cool     <= 1'b0;
         mul_mc   <= '0;
         mul_mp   <= '0;
         rsp_id   <= '0;
         rsp_prod <= '0;
`ifdef MULT_SCHED_RR_EN
         ptr      <= 3'(N_REQ - 1);
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               cool <= 1'b0;
               if (grant) begin
                  mul_mc <= sel_mc;
                  mul_mp <= sel_mp;
                  id_q   <= gnt;
`ifdef MULT_SCHED_RR_EN
                  ptr    <= gnt;
`endif
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               cnt   <= CW'(MUL_CYCLES);
               state <= S_RUN;
            end
            S_RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= S_CAPT;
               end
            end
            S_CAPT: begin
               rsp_prod <= mul_prod;
               rsp_id   <= id_q;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  cool  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed and randomized bench for mult_scheduler with a behavioural multiplier
// and a reference arbiter; honours MULT_SCHED_RR_EN the same way the design does.
module tb_mult_scheduler;

   localparam int N  = 4;
   localparam int MC = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [16*N-1:0] req_mc;
   logic [16*N-1:0] req_mp;
   logic            mul_start;
   logic [15:0]     mul_mc;
   logic [15:0]     mul_mp;
   logic [31:0]     mul_prod;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [2:0]      rsp_id;
   logic [31:0]     rsp_prod;
   logic            busy;

   logic signed [15:0] opa [N];
   logic signed [15:0] opb [N];

   int          total = 0;
   int          passed = 0;
   int          last = N - 1;
   logic [31:0] obs_prod;
   int          obs_id;
   bit          bad;
   int          seq [5];
   logic [N-1:0] v;
   int          hold;

   logic [31:0] mprod;
   int          mcnt;

   mult_scheduler #(.N_REQ(N), .MUL_CYCLES(MC)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_mc(req_mc), .req_mp(req_mp),
      .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
      .mul_prod(mul_prod),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_mc[16*i +: 16] = opa[i];
         req_mp[16*i +: 16] = opb[i];
      end
   end

   // Stand-in multiplier: product only becomes visible MC cycles after load.
   always @(posedge clk) begin
      if (reset) begin
         mcnt  <= 0;
         mprod <= 32'h0;
      end else if (mul_start) begin
         mcnt  <= MC;
         mprod <= 32'(int'($signed(mul_mc)) * int'($signed(mul_mp)));
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end
   end
   assign mul_prod = (mcnt == 0) ? mprod : 32'hDEAD_BEEF;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int model_grant(input logic [N-1:0] vv);
`ifdef MULT_SCHED_RR_EN
      for (int s = 1; s <= N; s++) begin
         if (vv[(last + s) % N]) return (last + s) % N;
      end
`else
      for (int k = 0; k < N; k++) begin
         if (vv[k]) return k;
      end
`endif
      return 0;
   endfunction

   task automatic reset_chk(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 0);
      chk({tag, "_mul_start"}, 64'(mul_start), 0);
      chk({tag, "_mul_mc"}, 64'(mul_mc), 0);
      chk({tag, "_mul_mp"}, 64'(mul_mp), 0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
      chk({tag, "_rsp_prod"}, 64'(rsp_prod), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      last = N - 1;
      #1;
   endtask

   // One full job: grant, load, 16 run cycles, capture, response with
   // optional back-pressure, then the mandatory idle cycle.
   task automatic job(input logic [N-1:0] vv, input int hh);
      int g;
      int w;
      logic [31:0] ep;
      bit b;
      req_valid = vv;
      rsp_ready = (hh == 0);
      #1;
      g = model_grant(vv);
      w = 0;
      while (req_ready == '0 && w < 8) begin
         tick();
         w++;
      end
      chk("grant", 64'(req_ready), 64'(N'(1) << g));
      if (req_ready !== (N'(1) << g)) return;
      last = g;
      ep = 32'(int'(opa[g]) * int'(opb[g]));
      tick();
      chk("load_start", 64'(mul_start), 1);
      chk("load_mc", 64'(mul_mc), 64'($unsigned(opa[g])));
      chk("load_mp", 64'(mul_mp), 64'($unsigned(opb[g])));
      chk("load_busy", 64'(busy), 1);
      b = 0;
      for (int c = 2; c <= 18; c++) begin
         tick();
         if (mul_start || rsp_valid || req_ready != '0 || !busy) b = 1;
      end
      chk("run_quiet", 64'(b), 0);
      tick();
      chk("rsp_valid", 64'(rsp_valid), 1);
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_prod", 64'(rsp_prod), 64'(ep));
      obs_prod = rsp_prod;
      obs_id = int'(rsp_id);
      b = 0;
      for (int h = 0; h < hh; h++) begin
         tick();
         if (!rsp_valid || rsp_prod !== ep || rsp_id !== 3'(g) ||
             req_ready != '0) b = 1;
      end
      if (hh > 0) chk("hold_stable", 64'(b), 0);
      rsp_ready = 1'b1;
      tick();
      chk("cool_ready", 64'(req_ready), 0);
      chk("cool_valid", 64'(rsp_valid), 0);
      chk("cool_busy", 64'(busy), 0);
      tick();
   endtask

   initial begin
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         opa[i] = '0;
         opb[i] = '0;
      end

      do_reset();
      reset_chk("reset");

      opa[2] = 16'sd3;
      opb[2] = 16'sd5;
      job(4'b0100, 0);
      chk("single_prod", 64'(obs_prod), 64'h0000_000F);
      chk("single_id", 64'(obs_id), 2);

      opa[0] = -16'sd7;
      opb[0] = 16'sd9;
      opa[1] = 16'sd32767;
      opb[1] = -16'sd2;
      job(4'b0011, 0);
      chk("neg_prod0", 64'(obs_prod), 64'hFFFF_FFC1);
      job(4'b0010, 0);
      chk("neg_prod1", 64'(obs_prod), 64'hFFFF_0002);

      do_reset();
`ifdef MULT_SCHED_RR_EN
      seq = '{0, 1, 2, 3, 0};
`else
      seq = '{0, 0, 0, 0, 0};
`endif
      for (int j = 0; j < 5; j++) begin
         job(4'b1111, 0);
         chk("arb_seq", 64'(obs_id), 64'(seq[j]));
      end

      job(4'b0011, 5);
      job(4'b0010, 0);
      chk("bp_next_id", 64'(obs_id), 1);

      opa[0] = 16'sd100;
      opb[0] = -16'sd3;
      do_reset();
      req_valid = 4'b0001;
      #1;
      chk("mid_grant", 64'(req_ready), 64'(N'(1) << model_grant(4'b0001)));
      tick();
      req_valid = '0;
      repeat (8) tick();
      chk("mid_busy", 64'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last = N - 1;
      #1;
      reset_chk("mid_reset");
      bad = 0;
      repeat (25) begin
         tick();
         if (rsp_valid || busy) bad = 1;
      end
      chk("mid_no_rsp", 64'(bad), 0);
      opa[0] = -16'sd4;
      opb[0] = -16'sd4;
      job(4'b0001, 0);
      chk("after_reset_prod", 64'(obs_prod), 64'h0000_0010);

      req_valid = 4'b0100;
      #2;
      req_valid = '0;
      tick();
      chk("glitch_busy", 64'(busy), 0);
      chk("glitch_start", 64'(mul_start), 0);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) begin
            opa[i] = 16'(int'($urandom_range(65534)) - 32767);
            opb[i] = 16'(int'($urandom_range(65534)) - 32767);
         end
         v = N'($urandom_range(1, 15));
         hold = int'($urandom_range(0, 3));
         job(v, hold);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
